// File: rtl/ccc_mgr_pkg.sv
// Shared types and helpers for the CCC PLL supervisor / reset sequencer.
package ccc_mgr_pkg;

  // Debug-visible state encoding, exported on STATE.
  typedef enum logic [2:0] {
    ST_POWERDOWN = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_DEBOUNCE  = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_e;

  // Smallest r such that 2**r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Increment v, holding at 2**w-1 instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] lim;
    lim = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= lim) ? lim : v + 32'd1;
  endfunction

endpackage

// File: rtl/ccc_lock_reset_manager_sync2_bit.sv
// Two-flop synchroniser for a single asynchronous level, resets to 0.
module sync2_bit (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Capture the asynchronous input through two flops to settle metastability.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ccc_lock_reset_manager.sv
// PLL supervisor and staggered reset sequencer for one PolarFire CCC.
// Runs on the free-running reference clock; PLL lock is treated as asynchronous.
module ccc_lock_reset_manager
  import ccc_mgr_pkg::*;
#(
  parameter int unsigned N_DOMAINS    = 3,
  parameter int unsigned PD_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned STAGGER      = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 PLL_LOCK,
  input  logic                 SW_RESTART,
  output logic                 PLL_POWERDOWN_N,
  output logic [N_DOMAINS-1:0] DOMAIN_RESET_N,
  output logic                 PLL_READY,
  output logic [CNT_W-1:0]     LOSS_COUNT,
  output logic [CNT_W-1:0]     FAIL_COUNT,
  output logic [2:0]           STATE
);

  localparam int unsigned SPAN_A = (PD_CYCLES > LOCK_TIMEOUT) ? PD_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned SPAN_B = (LOCK_STABLE > STAGGER * N_DOMAINS) ? LOCK_STABLE
                                                                      : STAGGER * N_DOMAINS;
  localparam int unsigned SPAN   = (SPAN_A > SPAN_B) ? SPAN_A : SPAN_B;
  localparam int unsigned CW     = clog2(SPAN + 1);

  logic                 lock_s;
  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 pd_n_q, pd_n_d;
  logic [N_DOMAINS-1:0] rst_q, rst_d;
  logic                 ready_q, ready_d;
  logic [CNT_W-1:0]     loss_q, loss_d;
  logic [CNT_W-1:0]     fail_q, fail_d;

  sync2_bit u_lock_sync (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .d_i    (PLL_LOCK),
    .q_o    (lock_s)
  );

  // Next-state logic: restart request beats lock loss, lock beats timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    loss_d  = loss_q;
    fail_d  = fail_q;
    if (SW_RESTART && (state_q != ST_POWERDOWN)) begin
      state_d = ST_POWERDOWN;
      cnt_d   = '0;
      rst_d   = '0;
    end else begin
      case (state_q)
        ST_POWERDOWN: begin
          rst_d = '0;
          if (cnt_q == CW'(PD_CYCLES - 1)) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_DEBOUNCE;
            cnt_d   = '0;
          end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
            state_d = ST_POWERDOWN;
            cnt_d   = '0;
            fail_d  = CNT_W'(sat_inc(32'(fail_q), CNT_W));
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == CW'(LOCK_STABLE - 1)) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RELEASE, ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_POWERDOWN;
            cnt_d   = '0;
            rst_d   = '0;
            loss_d  = CNT_W'(sat_inc(32'(loss_q), CNT_W));
          end else if (state_q == ST_RELEASE) begin
            // RUN is entered the cycle after the last domain is seen released.
            if (&rst_q) begin
              state_d = ST_RUN;
            end else begin
              for (int unsigned i = 0; i < N_DOMAINS; i++) begin
                if (cnt_q == CW'(STAGGER * i)) rst_d[i] = 1'b1;
              end
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_POWERDOWN;
          cnt_d   = '0;
          rst_d   = '0;
        end
      endcase
    end
    pd_n_d  = (state_d != ST_POWERDOWN);
    ready_d = (state_d == ST_RUN);
  end

  // State and registered outputs, all cleared by the asynchronous reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_POWERDOWN;
      cnt_q   <= '0;
      pd_n_q  <= 1'b0;
      rst_q   <= '0;
      ready_q <= 1'b0;
      loss_q  <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pd_n_q  <= pd_n_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      loss_q  <= loss_d;
      fail_q  <= fail_d;
    end
  end

  assign PLL_POWERDOWN_N = pd_n_q;
  assign DOMAIN_RESET_N  = rst_q;
  assign PLL_READY       = ready_q;
  assign LOSS_COUNT      = loss_q;
  assign FAIL_COUNT      = fail_q;
  assign STATE           = state_q;

endmodule

// File: tb/tb_ccc_lock_reset_manager.sv
// Scoreboard bench for ccc_lock_reset_manager: a phase/elapsed-time reference
// model queues the expected outputs per clock, a monitor compares them.
module tb_ccc_lock_reset_manager;

  localparam int ND    = 3;
  localparam int PDC   = 16;
  localparam int TOUT  = 4096;
  localparam int STAB  = 256;
  localparam int STG   = 8;
  localparam int CW    = 2;
  localparam int CMAX  = (1 << CW) - 1;

  localparam int P_PD   = 0;
  localparam int P_WAIT = 1;
  localparam int P_DEB  = 2;
  localparam int P_REL  = 3;
  localparam int P_RUN  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pll_lock = 1'b0;
  logic          sw_restart = 1'b0;
  logic          pd_n;
  logic [ND-1:0] dom_n;
  logic          ready;
  logic [CW-1:0] loss_cnt;
  logic [CW-1:0] fail_cnt;
  logic [2:0]    state;

  ccc_lock_reset_manager #(
    .N_DOMAINS    (ND),
    .PD_CYCLES    (PDC),
    .LOCK_TIMEOUT (TOUT),
    .LOCK_STABLE  (STAB),
    .STAGGER      (STG),
    .CNT_W        (CW)
  ) dut (
    .CLK             (clk),
    .RESET_N         (rst_n),
    .PLL_LOCK        (pll_lock),
    .SW_RESTART      (sw_restart),
    .PLL_POWERDOWN_N (pd_n),
    .DOMAIN_RESET_N  (dom_n),
    .PLL_READY       (ready),
    .LOSS_COUNT      (loss_cnt),
    .FAIL_COUNT      (fail_cnt),
    .STATE           (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          pd;
    logic [ND-1:0] dom;
    logic          rdy;
    logic [CW-1:0] loss;
    logic [CW-1:0] fail;
    logic [2:0]    st;
  } obs_t;

  obs_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: current phase, edges spent in it, event counts, lock history.
  int ph, t, m_loss, m_fail;
  bit h1, h2;

  function automatic int released(input int e);
    int r;
    if (e == 0) return 0;
    r = (e - 1) / STG + 1;
    return (r > ND) ? ND : r;
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_reset();
    ph = P_PD; t = 0; m_loss = 0; m_fail = 0; h1 = 1'b0; h2 = 1'b0;
  endtask

  function automatic obs_t model_out();
    obs_t o;
    o.pd   = (ph != P_PD);
    o.rdy  = (ph == P_RUN);
    o.dom  = (ph == P_RUN) ? '1 : (ph == P_REL) ? ND'((1 << released(t)) - 1) : '0;
    o.loss = CW'(m_loss);
    o.fail = CW'(m_fail);
    o.st   = 3'(ph);
    return o;
  endfunction

  task automatic model_edge();
    bit ls;
    ls = h2;
    h2 = h1;
    h1 = pll_lock;
    if (sw_restart && ph != P_PD) begin
      ph = P_PD; t = 0;
    end else begin
      case (ph)
        P_PD: begin
          t++;
          if (t == PDC) begin ph = P_WAIT; t = 0; end
        end
        P_WAIT: begin
          if (ls) begin ph = P_DEB; t = 0; end
          else begin
            t++;
            if (t == TOUT) begin m_fail = sat(m_fail); ph = P_PD; t = 0; end
          end
        end
        P_DEB: begin
          if (!ls) begin ph = P_WAIT; t = 0; end
          else begin
            t++;
            if (t == STAB) begin ph = P_REL; t = 0; end
          end
        end
        default: begin
          if (!ls) begin m_loss = sat(m_loss); ph = P_PD; t = 0; end
          else if (ph == P_REL) begin
            if (released(t) == ND) begin ph = P_RUN; t = 0; end
            else t++;
          end
        end
      endcase
    end
    expq.push_back(model_out());
  endtask

  // Monitor: compare DUT outputs with the oldest queued expectation on each falling edge.
  always @(negedge clk) begin
    obs_t e, a;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a = {pd_n, dom_n, ready, loss_cnt, fail_cnt, state};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs @%0t got pd=%b dom=%b rdy=%b loss=%0d fail=%0d st=%0d exp pd=%b dom=%b rdy=%b loss=%0d fail=%0d st=%0d",
                 $time, a.pd, a.dom, a.rdy, a.loss, a.fail, a.st,
                 e.pd, e.dom, e.rdy, e.loss, e.fail, e.st);
      end
    end
  end

  task automatic check_reset_vals(input string nm);
    obs_t a;
    a = {pd_n, dom_n, ready, loss_cnt, fail_cnt, state};
    checks++;
    if (a !== '0) begin
      errors++;
      $display("FAIL %s got pd=%b dom=%b rdy=%b loss=%0d fail=%0d st=%0d exp all zero",
               nm, a.pd, a.dom, a.rdy, a.loss, a.fail, a.st);
    end
  endtask

  task automatic step(input bit lk, input bit sw);
    pll_lock   = lk;
    sw_restart = sw;
    @(posedge clk);
    model_edge();
    #1;
    sw_restart = 1'b0;
  endtask

  task automatic hold(input bit lk, input int n);
    for (int i = 0; i < n; i++) step(lk, 1'b0);
  endtask

  task automatic hold_until(input bit lk, input int tph, input int tt);
    for (int i = 0; i < 20000; i++) begin
      if (ph == tph && t == tt) break;
      step(lk, 1'b0);
    end
  endtask

  initial begin
    model_reset();
    #23;
    check_reset_vals("por_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Bring-up with lock high: powerdown, debounce, staggered release, run.
    hold_until(1'b1, P_RUN, 0);
    hold(1'b1, 20);

    // Lock loss in RUN, then recovery.
    hold(1'b0, 5);
    hold_until(1'b1, P_RUN, 0);
    hold(1'b1, 10);

    // One-cycle glitch late in debounce.
    step(1'b1, 1'b1);
    hold_until(1'b1, P_DEB, 198);
    hold(1'b0, 1);
    hold_until(1'b1, P_RUN, 0);
    hold(1'b1, 5);

    // Software restart in RELEASE, then an ignored one during POWERDOWN.
    step(1'b1, 1'b1);
    hold_until(1'b1, P_REL, 3);
    step(1'b1, 1'b1);
    hold(1'b1, 5);
    step(1'b1, 1'b1);
    hold_until(1'b1, P_RUN, 0);
    hold(1'b1, 5);

    // Lock never returns: repeated timeouts saturate FAIL_COUNT.
    hold(1'b0, 5 * (PDC + TOUT) + 50);
    hold_until(1'b1, P_RUN, 0);
    hold(1'b1, 5);

    // Asynchronous reset between clock edges while releasing.
    step(1'b1, 1'b1);
    hold_until(1'b1, P_REL, 10);
    #2;
    expq.delete();
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("held_reset");
    model_reset();
    rst_n = 1'b1;

    // Randomised lock behaviour and restart requests.
    for (int seg = 0; seg < 25; seg++) begin
      case ($urandom_range(0, 3))
        0: hold(1'b1, int'($urandom_range(50, 400)));
        1: hold(1'b0, int'($urandom_range(1, 5)));
        2: begin
          step(1'b1, 1'b1);
          hold(1'b1, int'($urandom_range(20, 100)));
        end
        default: begin
          for (int k = 0; k < int'($urandom_range(10, 40)); k++)
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 15) == 0));
        end
      endcase
    end
    hold_until(1'b1, P_RUN, 0);
    hold(1'b1, 10);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
